// File: rtl/host_cmd_seq.sv
// Host-side command initiator: queues 16-bit commands, sends each as two 8N1 UART bytes
// (high byte first) and waits for a one-byte response or a timeout.
module host_cmd_seq #(
   parameter int unsigned BAUD_DIV     = 434,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned RESP_TIMEOUT = 20_000_000,
   parameter logic [7:0]  ACK_BYTE     = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd_in,
   input  logic        cmd_wr,
   output logic        full,
   output logic        empty,
   output logic        busy,
   output logic        TX,
   input  logic        RX,
   output logic [7:0]  resp,
   output logic        resp_vld,
   output logic        resp_ok,
   output logic        timeout
);

   localparam int unsigned BW = $clog2(BAUD_DIV);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(RESP_TIMEOUT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} state_t;

   state_t          state, state_nxt;
   logic [15:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_nxt;
   logic            wr_en, pop, load_lo, cap, to_fire;
   logic [15:0]     shadow;
   logic [9:0]      tx_shift;
   logic [BW-1:0]   baud_cnt;
   logic [3:0]      bit_cnt;
   logic [TW-1:0]   timer;
   logic            bit_end, frame_end;
   logic [1:0]      rx_sync;
   logic            rx_s, rx_prev, rx_active, rx_sample, rx_done_c;
   logic [BW-1:0]   rx_baud;
   logic [3:0]      rx_bit;
   logic [7:0]      rx_shift;

   assign wr_en     = cmd_wr && !full;
   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign frame_end = bit_end && (bit_cnt == 4'd9);
   assign TX        = tx_shift[0];

   // Command queue: flags follow the count so they always reflect the pre-edge occupancy
   always_comb begin
      count_nxt = count;
      case ({wr_en, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= cmd_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         count <= count_nxt;
         full  <= (count_nxt == DEPTH_C);
         empty <= (count_nxt == CW'(0));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Sequencer: a received byte takes priority over a timeout on the same edge
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load_lo   = 1'b0;
      cap       = 1'b0;
      to_fire   = 1'b0;
      case (state)
         IDLE: if (!empty) begin
            pop       = 1'b1;
            state_nxt = TX_HI;
         end
         TX_HI: if (frame_end) begin
            load_lo   = 1'b1;
            state_nxt = TX_LO;
         end
         TX_LO: if (frame_end) state_nxt = WAIT_RESP;
         WAIT_RESP: begin
            if (rx_done_c) begin
               cap       = 1'b1;
               state_nxt = IDLE;
            end else if (timer == TO_LAST) begin
               to_fire   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transmit shifter: {stop, data, start}, shifted right with idle ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift <= '1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shadow   <= '0;
      end else if (pop) begin
         shadow   <= mem[rd_ptr];
         tx_shift <= {1'b1, mem[rd_ptr][15:8], 1'b0};
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (load_lo) begin
         tx_shift <= {1'b1, shadow[7:0], 1'b0};
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (state == TX_HI || state == TX_LO) begin
         if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            tx_shift <= {1'b1, tx_shift[9:1]};
         end else begin
            baud_cnt <= baud_cnt + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  timer <= '0;
      else if (state != WAIT_RESP) timer <= '0;
      else                         timer <= timer + TW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         resp     <= '0;
         resp_ok  <= 1'b0;
         resp_vld <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         busy     <= (state_nxt != IDLE);
         resp_vld <= cap;
         timeout  <= to_fire;
         if (cap) begin
            resp    <= rx_shift;
            resp_ok <= (rx_shift == ACK_BYTE);
         end
      end
   end

   // Receiver: rx_bit 0 is the mid-start recheck, 1..8 data, 9 stop
   assign rx_s      = rx_sync[1];
   assign rx_sample = rx_active && ((rx_bit == 4'd0) ? (rx_baud == HALF_LAST)
                                                     : (rx_baud == BAUD_LAST));
   assign rx_done_c = rx_sample && (rx_bit == 4'd9) && rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync   <= 2'b11;
         rx_prev   <= 1'b1;
         rx_active <= 1'b0;
         rx_baud   <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
      end else begin
         rx_sync <= {rx_sync[0], RX};
         rx_prev <= rx_s;
         if (!rx_active) begin
            if (rx_prev && !rx_s) begin
               rx_active <= 1'b1;
               rx_baud   <= '0;
               rx_bit    <= '0;
            end
         end else if (rx_sample) begin
            rx_baud <= '0;
            if ((rx_bit == 4'd0 && rx_s) || rx_bit == 4'd9) begin
               rx_active <= 1'b0;
            end else begin
               rx_bit <= rx_bit + 4'd1;
               if (rx_bit != 4'd0) rx_shift <= {rx_s, rx_shift[7:1]};
            end
         end else begin
            rx_baud <= rx_baud + BW'(1);
         end
      end
   end

endmodule
